// File: rtl/pipe_memory_skid_if.sv
// MEM->WB handshake and payload bundle for pipe_memory_skid.
// The master drives the MEM-side payload and the writeback ready. The slave is the pipeline register.
interface pipe_memory_skid_if #(
    parameter int DATA_WIDTH      = 32,
    parameter int WRITE_WIDTH     = 5,
    parameter int RESULTSRC_WIDTH = 2
);
    logic                       flush;
    logic                       validm;
    logic                       readym;
    logic                       regwritem;
    logic [RESULTSRC_WIDTH-1:0] resultsrcm;
    logic [DATA_WIDTH-1:0]      aluresultm;
    logic [DATA_WIDTH-1:0]      readdatam;
    logic [WRITE_WIDTH-1:0]     rdm;
    logic [DATA_WIDTH-1:0]      pcplus4m;
    logic                       validw;
    logic                       readyw;
    logic                       regwritew;
    logic [RESULTSRC_WIDTH-1:0] resultsrcw;
    logic [DATA_WIDTH-1:0]      aluresultw;
    logic [DATA_WIDTH-1:0]      readdataw;
    logic [WRITE_WIDTH-1:0]     rdw;
    logic [DATA_WIDTH-1:0]      pcplus4w;
    logic [DATA_WIDTH-1:0]      resultw;
    logic [1:0]                 countw;

    modport master (
        output flush, validm, regwritem, resultsrcm, aluresultm, readdatam, rdm, pcplus4m, readyw,
        input  readym, validw, regwritew, resultsrcw, aluresultw, readdataw, rdw, pcplus4w,
               resultw, countw
    );

    modport slave (
        input  flush, validm, regwritem, resultsrcm, aluresultm, readdatam, rdm, pcplus4m, readyw,
        output readym, validw, regwritew, resultsrcw, aluresultw, readdataw, rdw, pcplus4w,
               resultw, countw
    );
endinterface

// File: rtl/pipe_memory_skid.sv
// MEM->WB pipeline register with a 2-entry skid buffer, synchronous flush,
// a local writeback result mux and x0 write suppression.
module pipe_memory_skid #(
    parameter int DATA_WIDTH      = 32,
    parameter int WRITE_WIDTH     = 5,
    parameter int RESULTSRC_WIDTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    pipe_memory_skid_if.slave   bus
);
    typedef struct packed {
        logic                       regwrite;
        logic [RESULTSRC_WIDTH-1:0] resultsrc;
        logic [DATA_WIDTH-1:0]      aluresult;
        logic [DATA_WIDTH-1:0]      readdata;
        logic [WRITE_WIDTH-1:0]     rd;
        logic [DATA_WIDTH-1:0]      pcplus4;
    } payload_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t   state, state_nxt;
    payload_t head, skid, incoming;
    logic     head_valid, skid_valid, acc, pop;
    logic     load_head_in, load_head_skid, load_skid;

    assign incoming = '{regwrite:  bus.regwritem,
                        resultsrc: bus.resultsrcm,
                        aluresult: bus.aluresultm,
                        readdata:  bus.readdatam,
                        rd:        bus.rdm,
                        pcplus4:   bus.pcplus4m};

    // The state encoding is the entry count, so both valid bits fall out of it.
    assign head_valid = (state != EMPTY);
    assign skid_valid = (state == FULL);
    assign bus.readym = !skid_valid;
    assign acc        = bus.validm & bus.readym;
    assign pop        = head_valid & bus.readyw;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_nxt      = state;
        load_head_in   = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        if (bus.flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: if (acc) begin
                    state_nxt    = ONE;
                    load_head_in = 1'b1;
                end
                ONE: begin
                    if (acc && pop) begin
                        load_head_in = 1'b1;
                    end else if (acc) begin
                        state_nxt = FULL;
                        load_skid = 1'b1;
                    end else if (pop) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: if (pop) begin
                    state_nxt      = ONE;
                    load_head_skid = 1'b1;
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) state <= EMPTY;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the payload registers are reset too, so the outputs are deterministic right after reset.
        if (!rst_n) begin
            head <= '0;
            skid <= '0;
        end else begin
            if (load_head_in) begin
                head <= incoming;
            end else if (load_head_skid) begin
                head <= skid;
                skid <= '0;
            end
            if (load_skid) skid <= incoming;
        end
    end

    assign bus.validw     = head_valid;
    assign bus.regwritew  = head_valid & head.regwrite & (head.rd != '0);
    assign bus.resultsrcw = head.resultsrc;
    assign bus.aluresultw = head.aluresult;
    assign bus.readdataw  = head.readdata;
    assign bus.rdw        = head.rd;
    assign bus.pcplus4w   = head.pcplus4;
    assign bus.countw     = state;

    always_comb begin
        bus.resultw = '0;
        if (head_valid) begin
            case (head.resultsrc)
                RESULTSRC_WIDTH'(0): bus.resultw = head.aluresult;
                RESULTSRC_WIDTH'(1): bus.resultw = head.readdata;
                RESULTSRC_WIDTH'(2): bus.resultw = head.pcplus4;
                default:             bus.resultw = '0;
            endcase
        end
    end
endmodule

// File: doc/pipe_memory_skid.md
Name: pipe_memory_skid

Overview:
- Parametrised next-generation MEM->WB pipeline register.
- Carries the MEM-stage payload, including the regwrite and resultsrc control fields, to writeback.
- Adds a valid/ready handshake with a 2-entry skid buffer so writeback stalls never drop an instruction, plus a synchronous flush.
- Resolves the writeback result mux locally and suppresses writes to x0.

Parameters:
DATA_WIDTH, 32, width of aluresult, readdata, pcplus4 and result datapaths
WRITE_WIDTH, 5, width of destination register index
RESULTSRC_WIDTH, 2, width of result-select control field (must be >= 2)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous kill of all held entries
validm  input  1  MEM stage presents an instruction
readym  output  1  block can accept an entry this cycle
regwritem  input  1  instruction writes the register file
resultsrcm  input  RESULTSRC_WIDTH  result select
aluresultm  input  DATA_WIDTH  ALU result
readdatam  input  DATA_WIDTH  load data
rdm  input  WRITE_WIDTH  destination register
pcplus4m  input  DATA_WIDTH  PC+4 for link writes
validw  output  1  head entry is valid
readyw  input  1  writeback consumes head entry
regwritew  output  1  gated register-file write enable
resultsrcw  output  RESULTSRC_WIDTH  head result select
aluresultw  output  DATA_WIDTH  head ALU result
readdataw  output  DATA_WIDTH  head load data
rdw  output  WRITE_WIDTH  head destination
pcplus4w  output  DATA_WIDTH  head PC+4
resultw  output  DATA_WIDTH  muxed writeback value
countw  output  2  entries held (0..2)

Behaviour:
- Storage:
  - Head register and skid register, each holding the full payload plus a valid bit.
  - The head drives all *w outputs.
- Reset (rst_n low, asynchronous):
  - Both valid bits cleared and all payload registers cleared to 0.
  - Outputs: validw=0, regwritew=0, resultw=0, countw=0, readym=1.
- readym = !skid_valid. It is registered state, with no combinational path from readyw.
- Accept: acc = validm & readym.
- Consume: pop = validw & readyw.
- States EMPTY(count 0), ONE(1), FULL(2):
  - EMPTY: acc -> ONE, entry loaded into head. Otherwise stay.
  - ONE, acc & pop: stay ONE, head reloaded with the new entry.
  - ONE, acc & !pop: -> FULL, new entry goes to skid.
  - ONE, !acc & pop: -> EMPTY.
  - ONE, neither: hold.
  - FULL: readym=0, so acc is impossible. pop -> ONE with skid moved to head and skid cleared. !pop -> hold.
- Latency: an entry accepted at edge N is visible on the *w outputs after edge N (1 cycle) when the block was EMPTY, or when ONE with a simultaneous pop.
- Ordering: strict FIFO. The head always holds the oldest entry.
- Flush:
  - On an edge with flush=1, both valid bits are cleared and the state becomes EMPTY.
  - That cycle's validm and readyw are ignored; no accept and no pop are counted.
  - Flush has priority over every other event.
  - Payload registers may keep stale data; outputs are qualified by validw.
- regwritew = validw & regwrite_head & (rd_head != 0).
- resultw is combinational from the head:
  - resultsrc 0 -> aluresult
  - 1 -> readdata
  - 2 -> pcplus4
  - any other value -> 0
  - Forced to 0 when validw=0.
- Payload holds stable while validw=1 & readyw=0 (AXI-style stability).
- Reset asserted mid-operation discards all entries immediately.
- countw reflects the registered state only.

Test Plan:
- Reset, then validm=1, rdm=5, regwritem=1, resultsrcm=0, aluresultm=0x1234, readyw=1 -> next cycle validw=1, rdw=5, regwritew=1, resultw=0x1234, countw=1.
- Back-to-back with readyw=1 every cycle: push pcplus4m=0x10,0x14,0x18 with resultsrcm=2 -> resultw shows 0x10,0x14,0x18 on consecutive cycles, readym stays 1, no loss or duplication.
- Stall: readyw=0, push A (aluresult 0xA) then B (0xB) -> countw=2, readym=0, head holds 0xA stable. Raise readyw -> 0xA then 0xB delivered, readym returns to 1 one cycle after the first pop.
- x0 suppression: rdm=0, regwritem=1, resultsrcm=1, readdatam=0xDEAD -> validw=1, regwritew=0, resultw=0xDEAD.
- Flush while FULL with validm=1 and readyw=1 in the same cycle -> next cycle countw=0, validw=0, readym=1, and the incoming entry is not captured.
- Assert rst_n=0 asynchronously mid-cycle while countw=2 -> validw, regwritew and countw drop to 0 immediately, without waiting for a clock edge. readym=1 after release.
